// File: rtl/noobs_mem_defs.sv
// Shared definitions for the data-memory sequencing controller: default
// address window, FSM/mux encodings and the memory request bundle.
package noobs_mem_defs;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 12'd8;
  localparam logic [ADDR_W-1:0] DEF_MAX_ADDR  = 12'd2048;

  typedef enum logic [2:0] {LOAD, COOL, RUN, DRAIN, DUMP, DONE} state_e;
  typedef enum logic [1:0] {SEL_IDLE, SEL_LD, SEL_CPU, SEL_DUMP} sel_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd;
    logic              wr;
    logic              en;
  } mem_req_t;

  // Unknown read bits from never-written locations are reported as 0.
  function automatic logic [DATA_W-1:0] x_to_zero(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = (d[i] === 1'b1);
    return r;
  endfunction
endpackage

// File: rtl/dmem_port_mux.sv
// Selects which requester (loader, CPU, dump engine or nobody) drives the
// data memory port.
module dmem_port_mux
  import noobs_mem_defs::*;
(
  input  sel_e     sel_i,
  input  mem_req_t ld_req_i,
  input  mem_req_t cpu_req_i,
  input  mem_req_t dump_req_i,
  output mem_req_t m_req_o
);
  always_comb begin
    m_req_o = '0;
    case (sel_i)
      SEL_LD:   m_req_o = ld_req_i;
      SEL_CPU:  m_req_o = cpu_req_i;
      SEL_DUMP: m_req_o = dump_req_i;
      default:  m_req_o = '0;
    endcase
  end
endmodule

// File: rtl/dmem_seq_ctrl.sv
// Sequences program load, CPU cool-down, run, drain and a full memory dump
// over a single shared data memory port.
module dmem_seq_ctrl
  import noobs_mem_defs::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter logic [ADDR_W-1:0] MAX_ADDR     = DEF_MAX_ADDR,
  parameter int                COOL_CYCLES  = 32,
  parameter int                DRAIN_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              cpu_halted,
  input  logic [ADDR_W-1:0] cpu_m_addr,
  input  logic [DATA_W-1:0] cpu_m_wr_data,
  input  logic              cpu_m_rd,
  input  logic              cpu_m_wr,
  input  logic              cpu_m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wr_data,
  output logic              m_rd,
  output logic              m_wr,
  output logic              m_en,
  input  logic [DATA_W-1:0] m_rd_data,
  output logic              cpu_reset_,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              rd_vld_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_issue;
  sel_e              sel;
  logic [ADDR_W-1:0] cur_addr;
  mem_req_t          ld_req, cpu_req, dump_req, m_req;

  assign cur_addr = BASE_ADDR + n_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    sel        = SEL_IDLE;
    ld_ready   = 1'b0;
    cpu_reset_ = 1'b0;
    rd_issue   = 1'b0;
    case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        sel      = SEL_LD;
        if (ld_valid) begin
          // Compare before increment so MAX_ADDR never wraps the counter.
          if (ld_last || cur_addr == MAX_ADDR) begin
            state_d = COOL;
            n_d     = '0;
            cnt_d   = '0;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      COOL: begin
        if (cnt_q == CNT_W'(COOL_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cpu_reset_ = 1'b1;
        sel        = SEL_CPU;
        if (cpu_halted) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cpu_reset_ = 1'b1;
        sel        = SEL_CPU;
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = DUMP;
          cnt_d   = '0;
          n_d     = '0;
          last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DUMP: begin
        if (!last_q) begin
          sel      = SEL_DUMP;
          rd_issue = 1'b1;
          if (cur_addr == MAX_ADDR) last_d = 1'b1;
          else                      n_d    = n_q + 1'b1;
        end
        // Leave only after the final beat has been presented.
        if (rd_vld_q && rd_addr_q == MAX_ADDR) state_d = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      n_q       <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rd_vld_q <= rd_issue;
      if (rd_issue) rd_addr_q <= cur_addr;
    end
  end

  assign ld_req   = '{addr: cur_addr, wr_data: ld_data, rd: 1'b0, wr: ld_valid, en: ld_valid};
  assign cpu_req  = '{addr: cpu_m_addr, wr_data: cpu_m_wr_data, rd: cpu_m_rd, wr: cpu_m_wr, en: cpu_m_en};
  assign dump_req = '{addr: cur_addr, wr_data: '0, rd: 1'b1, wr: 1'b0, en: 1'b1};

  dmem_port_mux u_mux (
    .sel_i      (sel),
    .ld_req_i   (ld_req),
    .cpu_req_i  (cpu_req),
    .dump_req_i (dump_req),
    .m_req_o    (m_req)
  );

  assign m_addr     = m_req.addr;
  assign m_wr_data  = m_req.wr_data;
  assign m_rd       = m_req.rd;
  assign m_wr       = m_req.wr;
  assign m_en       = m_req.en;
  assign dump_valid = rd_vld_q;
  assign dump_addr  = rd_addr_q;
  assign dump_data  = rd_vld_q ? x_to_zero(m_rd_data) : '0;
  assign done       = (state_q == DONE);
endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Directed bench for dmem_seq_ctrl: load, cool-down, CPU run, drain, full
// dump, reset mid-dump and loader overflow, against a behavioural memory.
module tb_dmem_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, ld_last, ld_ready;
  logic [7:0]  ld_data;
  logic        cpu_halted;
  logic [11:0] cpu_m_addr;
  logic [7:0]  cpu_m_wr_data;
  logic        cpu_m_rd, cpu_m_wr, cpu_m_en;
  logic [11:0] m_addr;
  logic [7:0]  m_wr_data;
  logic        m_rd, m_wr, m_en;
  logic [7:0]  m_rd_data;
  logic        cpu_reset_;
  logic        dump_valid;
  logic [11:0] dump_addr;
  logic [7:0]  dump_data;
  logic        done;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  dmem_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_halted(cpu_halted),
    .cpu_m_addr(cpu_m_addr), .cpu_m_wr_data(cpu_m_wr_data),
    .cpu_m_rd(cpu_m_rd), .cpu_m_wr(cpu_m_wr), .cpu_m_en(cpu_m_en),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd(m_rd), .m_wr(m_wr), .m_en(m_en),
    .m_rd_data(m_rd_data),
    .cpu_reset_(cpu_reset_),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .done(done)
  );

  // Behavioural data memory with one-cycle read latency; unwritten reads give X.
  logic [7:0] mem [4096];
  bit         wrn [4096];
  always @(posedge clk) begin
    if (m_en && m_wr) begin
      mem[m_addr] <= m_wr_data;
      wrn[m_addr] <= 1'b1;
    end
    if (m_en && m_rd) m_rd_data <= wrn[m_addr] ? mem[m_addr] : 8'hxx;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_dump(input int a);
    case (a)
      8:       return 8'hA0;
      9:       return 8'hA1;
      10:      return 8'hA2;
      11:      return 8'hA3;
      'h100:   return 8'h5A;
      'h7FF:   return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  int cyc, bad, nw;
  logic [11:0] last_wa, first_wa;
  bit found;

  initial begin
    reset = 1'b1;
    ld_valid = 0; ld_data = 0; ld_last = 0; cpu_halted = 0;
    cpu_m_addr = 0; cpu_m_wr_data = 0; cpu_m_rd = 0; cpu_m_wr = 0; cpu_m_en = 0;
    repeat (2) tick;
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_cpu_reset_", cpu_reset_, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Load A0..A3, last on A3.
    for (int i = 0; i < 4; i++) begin
      tick;
      ld_valid = 1; ld_data = 8'hA0 + 8'(i); ld_last = (i == 3);
      #1;
      chk("ld_m_en", m_en, 1);
      chk("ld_m_wr", m_wr, 1);
      chk("ld_m_addr", m_addr, 32'(8 + i));
      chk("ld_m_wr_data", m_wr_data, 32'(8'hA0 + i));
    end
    cyc = 0; bad = 0;
    while (cpu_reset_ == 1'b0 && cyc < 100) begin
      tick;
      ld_valid = 0; ld_last = 0;
      #1;
      cyc++;
      if (!cpu_reset_ && m_en) bad++;
    end
    chk("cool_release_cycle", cyc, 33);
    chk("cool_port_idle", bad, 0);
    chk("run_ld_ready", ld_ready, 0);

    // RUN: CPU owns the port; loader activity is ignored.
    cpu_m_en = 1; cpu_m_wr = 1; cpu_m_addr = 12'h100; cpu_m_wr_data = 8'h5A;
    ld_valid = 1; ld_data = 8'hFF;
    #1;
    chk("run_m_addr", m_addr, 12'h100);
    chk("run_m_wr_data", m_wr_data, 8'h5A);
    chk("run_m_wr", m_wr, 1);
    chk("run_m_rd", m_rd, 0);
    tick;
    cpu_m_addr = 12'h7FF; cpu_m_wr_data = 8'h3C;
    #1;
    chk("run_m_addr2", m_addr, 12'h7FF);
    tick;
    ld_valid = 0; cpu_m_wr = 0; cpu_m_rd = 1; cpu_m_addr = 12'h123;
    #1;
    chk("run_m_rd2", m_rd, 1);
    chk("run_m_wr2", m_wr, 0);

    // One-cycle halt pulse; drain must run its full length regardless.
    cpu_halted = 1;
    tick;
    cpu_halted = 0;
    #1;
    cyc = 0;
    while (cpu_reset_ && cyc < 50) begin
      if (cyc == 3) chk("drain_cpu_mux", m_addr, 12'h123);
      cyc++;
      tick;
      #1;
    end
    chk("drain_len", cyc, 10);
    chk("dump0_m_rd", m_rd, 1);
    chk("dump0_m_en", m_en, 1);
    chk("dump0_m_wr", m_wr, 0);
    chk("dump0_m_addr", m_addr, 8);
    chk("dump0_dump_valid", dump_valid, 0);

    for (int a = 8; a <= 2048; a++) begin
      tick;
      #1;
      chk("dump_valid", dump_valid, 1);
      chk("dump_addr", dump_addr, 32'(a));
      chk("dump_data", dump_data, 32'(exp_dump(a)));
      if (a == 2048) chk("done_not_yet", done, 0);
    end
    tick;
    #1;
    chk("done_set", done, 1);
    chk("done_dump_valid", dump_valid, 0);
    chk("done_m_en", m_en, 0);
    repeat (3) tick;
    #1;
    chk("done_sticky", done, 1);
    chk("done_cpu_reset_", cpu_reset_, 0);

    // Reset asserted mid-dump.
    reset = 1;
    tick;
    reset = 0;
    ld_valid = 1; ld_last = 1; ld_data = 8'h11;
    tick;
    ld_valid = 0; ld_last = 0;
    cyc = 0;
    while (!cpu_reset_ && cyc < 100) begin tick; cyc++; end
    chk("rst2_run_reached", cpu_reset_, 1);
    cpu_halted = 1;
    tick;
    cpu_halted = 0;
    found = 0; cyc = 0;
    while (!found && cyc < 3000) begin
      #1;
      if (m_rd && m_en && m_addr == 12'h200) found = 1;
      else begin tick; cyc++; end
    end
    chk("rst2_dump_reached", found, 1);
    chk("rst2_pre_dump_valid", dump_valid, 1);
    reset = 1;
    #1;
    chk("rst2_dump_valid", dump_valid, 0);
    chk("rst2_cpu_reset_", cpu_reset_, 0);
    chk("rst2_ld_ready", ld_ready, 1);
    chk("rst2_m_en", m_en, 0);
    chk("rst2_done", done, 0);
    tick;
    reset = 0;

    // Loader overflow: no ld_last, more bytes than the window holds.
    nw = 0; last_wa = 0; first_wa = 12'hFFF;
    ld_valid = 1; ld_last = 0;
    for (int i = 0; i < 2050; i++) begin
      ld_data = 8'(i);
      #1;
      if (m_en && m_wr) begin
        if (nw == 0) first_wa = m_addr;
        nw++;
        last_wa = m_addr;
      end
      tick;
    end
    ld_valid = 0;
    #1;
    chk("ovf_writes", nw, 2041);
    chk("ovf_first_addr", first_wa, 8);
    chk("ovf_last_addr", last_wa, 2048);
    chk("ovf_ld_ready", ld_ready, 0);
    chk("ovf_m_en", m_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
